trace_monitor: RTL and testbench
================================

TRACE_MONITOR -- requirements
Module: trace_monitor

Interface
REQ-001 Parameter DATA_W, default 5, width of the watched bus.
REQ-002 Parameter TS_W, default 16, width of the timestamp.
REQ-003 Parameter DEPTH, default 8, event buffer entries; power of two, >= 2.
REQ-004 Parameter OVF_W, default 8, width of the dropped-event counter.
REQ-005 Clocking SHALL be one clock, and reset SHALL be asynchronous and active-low.
REQ-006 clock  input  1  sole clock; all state updates on rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 mon_en  input  1  monitoring enable; low suspends capture (monitor-off).
REQ-009 mode  input  1  0 = capture on change only, 1 = capture every enabled cycle.
REQ-010 watch  input  DATA_W  bus being traced.
REQ-011 rd_valid  output  1  buffer non-empty; head entry presented.
REQ-012 rd_ready  input  1  consumer accepts head entry.
REQ-013 rd_data  output  DATA_W  watch value of head entry.
REQ-014 rd_ts  output  TS_W  timestamp of head entry.
REQ-015 count  output  clog2(DEPTH)+1  entries currently held.
REQ-016 overflow_cnt  output  OVF_W  captures dropped because buffer full.

Function
REQ-017 Free-running timestamp SHALL be 0 in the first cycle after reset release, +1 per cycle, and wrap from 2^TS_W-1 to 0.
REQ-018 Register prev SHALL sample watch every cycle regardless of mon_en.
REQ-019 An arm flag SHALL be set by a rising edge of mon_en (mon_en high, previous-cycle mon_en low) and cleared by the next capture.
REQ-020 Capture condition: mon_en high AND (mode = 1 OR watch != prev OR arm); the first enabled cycle always captures.
REQ-021 A capture SHALL write {current timestamp, current watch} into the buffer tail in the same edge.
REQ-022 Latency: a captured entry SHALL appear on rd_* no earlier than the cycle after capture; no combinational bypass.
REQ-023 rd_valid SHALL equal (count != 0); rd_data/rd_ts SHALL show the oldest entry, FIFO order.
REQ-024 Pop SHALL occur when rd_valid and rd_ready are both high; rd_* SHALL hold stable while rd_valid is high and rd_ready is low.
REQ-025 When full and no pop occurs, a capture SHALL be discarded and overflow_cnt incremented, saturating at 2^OVF_W-1.
REQ-026 Simultaneous pop and capture when full SHALL accept the capture, count unchanged, no overflow increment.
REQ-027 Simultaneous pop and capture at any other level SHALL leave count unchanged.
REQ-028 With mon_en low, no captures SHALL occur, but draining via rd_ready SHALL continue.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.

Reset
REQ-030 reset_n low SHALL immediately force: timestamp 0, prev 0, arm 0, previous mon_en 0, pointers 0, count 0, rd_valid 0, rd_data 0, rd_ts 0, overflow_cnt 0.
REQ-031 Reset mid-operation SHALL discard all buffered entries; rd_valid SHALL be 0 from the assertion of reset_n low onward.
REQ-032 If mon_en is high at reset release, the first cycle SHALL capture (arm via rising-edge rule).

Structure
REQ-033 Package trace_monitor_pkg SHALL hold mode constants (MODE_CHANGE = 0, MODE_ALL = 1) and the entry-record typedef.
REQ-034 Buffer SHALL be sub-module trace_fifo (parametrised width/depth, push/pop/full/empty/count); trace_monitor holds timestamp, prev, arm, capture and overflow logic.

Verification
REQ-035 Reset, mon_en=1, mode=0, watch=5'b10101 held -> exactly one entry {ts=0, data=10101}; rd_valid high at cycle 1.
REQ-036 mode=0, watch changes at ts 10, 20, 30 -> entries at ts 10, 20, 30 only, in order.
REQ-037 mon_en low for ts 11..14 with watch toggling each cycle -> no entries in 11..14; an entry is captured at ts 15 (re-arm) even if watch is unchanged.
REQ-038 mode=1, rd_ready=0, DEPTH=8, 12 enabled cycles -> count=8, overflow_cnt=4; then rd_ready=1 -> 8 pops at ts 0..7.
REQ-039 Full buffer, rd_ready=1 and capture in the same cycle -> count stays 8, overflow_cnt unchanged.
REQ-040 reset_n pulsed low with count=5 -> count=0, rd_valid=0 immediately; timestamp restarts at 0.

Source files
------------

// File: rtl/trace_monitor_pkg.sv
// Shared constants and the trace entry record for the trace monitor.
package trace_monitor_pkg;

    localparam logic MODE_CHANGE = 1'b0;
    localparam logic MODE_ALL    = 1'b1;

    localparam int DEF_DATA_W = 5;
    localparam int DEF_TS_W   = 16;

    // Entry layout as stored in the buffer: timestamp in the upper bits.
    typedef struct packed {
        logic [DEF_TS_W-1:0]   ts;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular entry buffer; a push into a full buffer is accepted only alongside a pop.
module trace_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign count   = count_reg;
    // Gate the head so a drained or reset buffer presents zero, not stale data.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/trace_monitor.sv
// Timestamped bus trace: captures changes (or every cycle) into a FIFO with drop counting.
module trace_monitor
    import trace_monitor_pkg::*;
#(
    parameter int DATA_W = 5,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 8,
    parameter int OVF_W  = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   mon_en,
    input  logic                   mode,
    input  logic [DATA_W-1:0]      watch,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [DATA_W-1:0]      rd_data,
    output logic [TS_W-1:0]        rd_ts,
    output logic [$clog2(DEPTH):0] count,
    output logic [OVF_W-1:0]       overflow_cnt
);
    logic [TS_W-1:0]   ts_reg;
    logic [DATA_W-1:0] prev_reg;
    logic              arm_reg;
    logic              mon_en_prev_reg;
    logic [OVF_W-1:0]  ovf_reg;

    logic rise;
    logic capture;
    logic pop;
    logic full;
    logic empty;
    logic drop;
    logic [TS_W+DATA_W-1:0] head;

    // The rising edge arms combinationally so the first enabled cycle captures.
    assign rise    = mon_en & ~mon_en_prev_reg;
    assign capture = mon_en & ((mode == MODE_ALL) | (watch != prev_reg) | arm_reg | rise);
    assign pop     = rd_valid & rd_ready;
    assign drop    = capture & full & ~pop;

    trace_fifo #(
        .WIDTH(TS_W + DATA_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset_n(reset_n),
        .push   (capture),
        .pop    (pop),
        .wr_data({ts_reg, watch}),
        .rd_data(head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    assign rd_valid     = ~empty;
    assign rd_ts        = head[TS_W+DATA_W-1:DATA_W];
    assign rd_data      = head[DATA_W-1:0];
    assign overflow_cnt = ovf_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_reg          <= '0;
            prev_reg        <= '0;
            arm_reg         <= 1'b0;
            mon_en_prev_reg <= 1'b0;
            ovf_reg         <= '0;
        end else begin
            ts_reg          <= ts_reg + TS_W'(1);
            prev_reg        <= watch;
            mon_en_prev_reg <= mon_en;
            arm_reg         <= (arm_reg | rise) & ~capture;
            if (drop && (ovf_reg != '1)) begin
                ovf_reg <= ovf_reg + OVF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_trace_monitor.sv
// Directed self-checking bench for trace_monitor at default parameters.
module tb_trace_monitor;
    import trace_monitor_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        mon_en = 1'b0;
    logic        mode = 1'b0;
    logic [4:0]  watch = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [4:0]  rd_data;
    logic [15:0] rd_ts;
    logic [3:0]  count;
    logic [7:0]  overflow_cnt;

    int checks = 0;
    int errors = 0;

    entry_t exp_q [5];

    trace_monitor dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mon_en      (mon_en),
        .mode        (mode),
        .watch       (watch),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_ts       (rd_ts),
        .count       (count),
        .overflow_cnt(overflow_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        step();
        reset_n = 1'b1;
    endtask

    function automatic logic [4:0] wv(input int t);
        if (t < 10)       return 5'h00;
        else if (t == 10) return 5'h0A;
        else if (t == 11) return 5'h1F;
        else if (t == 12) return 5'h00;
        else if (t == 13) return 5'h1F;
        else if (t < 20)  return 5'h03;
        else if (t < 30)  return 5'h11;
        else              return 5'h1E;
    endfunction

    initial begin
        // Reset state, held watch with change mode: exactly one entry at ts 0.
        mon_en = 1'b1; mode = MODE_CHANGE; watch = 5'b10101;
        #3;
        check("reset_valid", 32'(rd_valid), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_data", 32'(rd_data), 32'd0);
        check("reset_ts", 32'(rd_ts), 32'd0);
        check("reset_ovf", 32'(overflow_cnt), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("t1_valid", 32'(rd_valid), 32'd1);
        check("t1_count", 32'(count), 32'd1);
        check("t1_data", 32'(rd_data), 32'h15);
        check("t1_ts", 32'(rd_ts), 32'd0);
        repeat (3) step();
        check("t1_hold_count", 32'(count), 32'd1);
        check("t1_hold_ts", 32'(rd_ts), 32'd0);
        check("t1_hold_data", 32'(rd_data), 32'h15);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        check("t1_popped_valid", 32'(rd_valid), 32'd0);

        // Change capture, monitor-off window 11..14, re-arm at 15.
        watch = wv(0);
        do_reset();
        for (int t = 0; t < 36; t++) begin
            mon_en = !(t >= 11 && t <= 14);
            watch = wv(t);
            if (t == 15) check("t2_count_at15", 32'(count), 32'd2);
            step();
        end
        check("t2_count_end", 32'(count), 32'd5);
        exp_q[0] = '{ts: 16'd0,  data: 5'h00};
        exp_q[1] = '{ts: 16'd10, data: 5'h0A};
        exp_q[2] = '{ts: 16'd15, data: 5'h03};
        exp_q[3] = '{ts: 16'd20, data: 5'h11};
        exp_q[4] = '{ts: 16'd30, data: 5'h1E};
        mon_en = 1'b0;
        rd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_valid%0d", k), 32'(rd_valid), 32'd1);
            check($sformatf("t2_ts%0d", k), 32'(rd_ts), 32'(exp_q[k].ts));
            check($sformatf("t2_data%0d", k), 32'(rd_data), 32'(exp_q[k].data));
            step();
        end
        rd_ready = 1'b0;
        check("t2_drained_valid", 32'(rd_valid), 32'd0);
        check("t2_drained_count", 32'(count), 32'd0);

        // Capture-all into a full buffer, then drain in order.
        mon_en = 1'b1; mode = MODE_ALL; watch = 5'd0;
        do_reset();
        for (int t = 0; t < 12; t++) begin
            watch = 5'(t);
            step();
        end
        check("t3_full_count", 32'(count), 32'd8);
        check("t3_ovf", 32'(overflow_cnt), 32'd4);
        mon_en = 1'b0;
        rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t3_pop_ts%0d", k), 32'(rd_ts), 32'(k));
            check($sformatf("t3_pop_data%0d", k), 32'(rd_data), 32'(k));
            watch = 5'(12 + k);
            step();
        end
        check("t3_empty_count", 32'(count), 32'd0);

        // Refill, then pop and capture together while full.
        mon_en = 1'b1;
        rd_ready = 1'b0;
        for (int t = 20; t < 28; t++) begin
            watch = 5'(t);
            step();
        end
        check("t4_full_count", 32'(count), 32'd8);
        rd_ready = 1'b1;
        watch = 5'(28);
        step();
        check("t4_simul_count", 32'(count), 32'd8);
        check("t4_simul_ovf", 32'(overflow_cnt), 32'd4);
        check("t4_simul_head_ts", 32'(rd_ts), 32'd21);
        rd_ready = 1'b0;
        step();
        check("t4_drop_ovf", 32'(overflow_cnt), 32'd5);
        repeat (260) step();
        check("t4_ovf_saturate", 32'(overflow_cnt), 32'd255);
        check("t4_sat_count", 32'(count), 32'd8);

        // Reset with a partly filled buffer.
        mon_en = 1'b0;
        do_reset();
        mon_en = 1'b1;
        mode = MODE_ALL;
        repeat (5) step();
        mon_en = 1'b0;
        step();
        check("t5_count5", 32'(count), 32'd5);
        check("t5_head_ts", 32'(rd_ts), 32'd0);
        reset_n = 1'b0;
        #1;
        check("t5_rst_count", 32'(count), 32'd0);
        check("t5_rst_valid", 32'(rd_valid), 32'd0);
        check("t5_rst_ts", 32'(rd_ts), 32'd0);
        mon_en = 1'b1; mode = MODE_CHANGE; watch = 5'h07;
        step();
        reset_n = 1'b1;
        step();
        check("t5_restart_valid", 32'(rd_valid), 32'd1);
        check("t5_restart_ts", 32'(rd_ts), 32'd0);
        check("t5_restart_data", 32'(rd_data), 32'h07);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
